// File: rtl/acc_pkg.sv
// Shared definitions for the temporal FP16 accumulator datapath.
// FP16_W/LANES describe one accumulated vector; state_t is the control
// state encoding used by the result writer.
package acc_pkg;

  localparam int FP16_W    = 16;
  localparam int LANES     = 16;
  localparam int ACC_VEC_W = LANES * FP16_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/vec_fifo.sv
// Synchronous FIFO holding whole accumulated vectors.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   push, push_data       write request and vector
//   pop                   read request (head advances)
//   pop_data              current head entry (valid when !empty)
//   full, empty           occupancy flags
// A push while full is accepted only when a pop happens in the same cycle,
// since the slot is freed at the same edge.
module vec_fifo #(
  parameter int DATA_W = 256,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              do_push;
  logic              do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign full     = (count == (PTR_W+1)'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two; the extra
  // count bit distinguishes full from empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/acc_result_writer.sv
// Result writer: buffers completed accumulator vectors (no backpressure on
// the input side) and streams them as BEAT_W-bit beats to a valid/ready
// memory write port at consecutive byte addresses.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   cfg_start                pulse: latch base/count and start a job (IDLE only)
//   cfg_base_addr            byte address of the first beat
//   cfg_num_vectors          vectors expected in this job
//   in_valid, in_vector      single-cycle vector from the accumulator
//   wr_valid/ready/addr/data/last   write beat port, low beat first
//   busy                     job running
//   done                     one-cycle pulse when the last beat is accepted
//   err_overflow             sticky: a vector was dropped on a full FIFO
//   err_unexpected           sticky: a vector arrived when none was expected
module acc_result_writer
  import acc_pkg::*;
#(
  parameter int DATA_W     = ACC_VEC_W,
  parameter int BEAT_W     = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 32,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_start,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic [CNT_W-1:0]  cfg_num_vectors,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_vector,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [BEAT_W-1:0] wr_data,
  output logic              wr_last,
  output logic              busy,
  output logic              done,
  output logic              err_overflow,
  output logic              err_unexpected
);

  localparam int BEATS  = DATA_W / BEAT_W;
  localparam int BIDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BIDX_W-1:0] LAST_BEAT = BIDX_W'(BEATS - 1);
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(BEAT_W / 8);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  num_q;
  logic [CNT_W-1:0]  rcv_cnt;
  logic [CNT_W-1:0]  sent_cnt;
  logic [BIDX_W-1:0] beat_idx;

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] head;
  logic [BEAT_W-1:0] head_beats [BEATS];

  logic              start_ok;
  logic              in_slot;
  logic              handshake;
  logic              drop_full;
  logic              unexpected;
  logic              final_beat;

  vec_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (in_vector),
    .pop       (fifo_pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // in_slot: a vector the job still expects. Whether it is stored depends
  // on room in the FIFO, counting a slot freed by a same-cycle pop.
  assign start_ok   = cfg_start && (state == IDLE);
  assign in_slot    = in_valid && (state == RUN) && (rcv_cnt < num_q);
  assign handshake  = wr_valid && wr_ready;
  assign fifo_pop   = handshake && wr_last;
  assign fifo_push  = in_slot && (!fifo_full || fifo_pop);
  assign drop_full  = in_slot && fifo_full && !fifo_pop;
  assign unexpected = in_valid && !in_slot;
  assign final_beat = fifo_pop && (sent_cnt == num_q - CNT_W'(1));

  // Split the head vector into beats so the beat index selects a word.
  always_comb begin
    for (int i = 0; i < BEATS; i++) begin
      head_beats[i] = head[i*BEAT_W +: BEAT_W];
    end
  end

  // Data and last are qualified by valid so the port reads as zero when idle.
  assign wr_valid = (state == RUN) && !fifo_empty;
  assign wr_last  = wr_valid && (beat_idx == LAST_BEAT);
  assign wr_data  = wr_valid ? head_beats[beat_idx] : '0;
  assign wr_addr  = addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Completion is driven by beats leaving the port, not vectors arriving,
  // so a job with a dropped vector stays in RUN until reset.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_start) state_nxt = (cfg_num_vectors == '0) ? DONE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (final_beat) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Job counters, beat index and address generator. Beat index and address
  // only move on an accepted beat, which keeps the port stable under stall.
  // Error set has priority over the clear from a start in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q         <= '0;
      num_q          <= '0;
      rcv_cnt        <= '0;
      sent_cnt       <= '0;
      beat_idx       <= '0;
      err_overflow   <= 1'b0;
      err_unexpected <= 1'b0;
    end else begin
      if (start_ok) begin
        addr_q         <= cfg_base_addr;
        num_q          <= cfg_num_vectors;
        rcv_cnt        <= '0;
        sent_cnt       <= '0;
        beat_idx       <= '0;
        err_overflow   <= 1'b0;
        err_unexpected <= 1'b0;
      end else begin
        if (handshake) begin
          addr_q   <= addr_q + ADDR_STEP;
          beat_idx <= wr_last ? '0 : beat_idx + BIDX_W'(1);
        end
        if (fifo_pop) sent_cnt <= sent_cnt + CNT_W'(1);
        if (in_slot)  rcv_cnt  <= rcv_cnt + CNT_W'(1);
      end
      if (drop_full)  err_overflow   <= 1'b1;
      if (unexpected) err_unexpected <= 1'b1;
    end
  end

endmodule

// File: tb/tb_acc_result_writer.sv
// Self-checking bench for acc_result_writer.
// A scoreboard keeps the expected beat stream as a queue built from the
// vectors the bench sends, and checks the write port, busy/done and the
// error flags every cycle. Job-level expectations come from a table and
// from hand-written corner-case sequences, plus randomized jobs.
module tb_acc_result_writer;

  localparam int DEPTH = 4;
  localparam int BEATS = 4;
  localparam int P_IDLE = 0;
  localparam int P_RUN  = 1;
  localparam int P_DONE = 2;

  typedef struct {
    logic [31:0] addr;
    logic [63:0] data;
    logic        last;
  } beat_t;

  typedef struct {
    logic [31:0] base;
    int          num;
    int          nvec;
    int          gap;
    int          rmode;
    logic        exp_ovf;
    logic        exp_unexp;
    logic        exp_done;
    int          exp_beats;
  } job_t;

  logic         clk;
  logic         rst;
  logic         cfg_start;
  logic [31:0]  cfg_base_addr;
  logic [15:0]  cfg_num_vectors;
  logic         in_valid;
  logic [255:0] in_vector;
  logic         wr_valid;
  logic         wr_ready;
  logic [31:0]  wr_addr;
  logic [63:0]  wr_data;
  logic         wr_last;
  logic         busy;
  logic         done;
  logic         err_overflow;
  logic         err_unexpected;

  int n_tests = 0;
  int n_fail  = 0;

  // Scoreboard / reference model state
  beat_t       exp_q[$];
  int          m_phase;
  int          m_num;
  int          m_rcv;
  int          m_sent;
  int          m_occ;
  logic [31:0] m_addr;
  logic        m_ovf;
  logic        m_unexp;
  bit          mon_en;
  int          nbeats;
  int          done_cnt;
  int          ready_mode;

  acc_result_writer dut (
    .clk             (clk),
    .rst             (rst),
    .cfg_start       (cfg_start),
    .cfg_base_addr   (cfg_base_addr),
    .cfg_num_vectors (cfg_num_vectors),
    .in_valid        (in_valid),
    .in_vector       (in_vector),
    .wr_valid        (wr_valid),
    .wr_ready        (wr_ready),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .wr_last         (wr_last),
    .busy            (busy),
    .done            (done),
    .err_overflow    (err_overflow),
    .err_unexpected  (err_unexpected)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic failNow(input string name);
    n_tests++;
    n_fail++;
    $display("[TB] FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  function automatic logic [255:0] randVec();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic resetModel();
    exp_q.delete();
    m_phase = P_IDLE;
    m_num   = 0;
    m_rcv   = 0;
    m_sent  = 0;
    m_occ   = 0;
    m_addr  = '0;
    m_ovf   = 1'b0;
    m_unexp = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Wr_ready pattern: 0 always, 1 toggle, 2 random, 3 stalled, 4 manual.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: wr_ready = 1'b1;
        1: wr_ready = ~wr_ready;
        2: wr_ready = 1'($urandom_range(0, 1));
        3: wr_ready = 1'b0;
        default: ;
      endcase
    end
  end

  // Scoreboard: check the outputs against the model, then advance the
  // model with what will happen at the coming rising edge.
  initial begin : monitor
    beat_t b;
    int    cur;
    logic  ev;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        cur = m_phase;
        ev  = (cur == P_RUN) && (m_occ > 0);
        checkOutput("wr_valid", wr_valid, ev);
        checkOutput("busy", busy, cur == P_RUN);
        checkOutput("done", done, cur == P_DONE);
        checkOutput("err_overflow", err_overflow, m_ovf);
        checkOutput("err_unexpected", err_unexpected, m_unexp);
        if (done) done_cnt++;
        if (ev && exp_q.size() > 0) begin
          b = exp_q[0];
          checkOutput("wr_addr", wr_addr, b.addr);
          checkOutput("wr_data", wr_data, b.data);
          checkOutput("wr_last", wr_last, b.last);
        end
        if (cur == P_DONE) m_phase = P_IDLE;
        if (ev && wr_ready && exp_q.size() > 0) begin
          b = exp_q.pop_front();
          nbeats++;
          if (b.last) begin
            m_occ--;
            m_sent++;
            if (m_sent == m_num) m_phase = P_DONE;
          end
        end
        if (cfg_start && cur == P_IDLE) begin
          m_num   = int'(cfg_num_vectors);
          m_addr  = cfg_base_addr;
          m_rcv   = 0;
          m_sent  = 0;
          m_ovf   = 1'b0;
          m_unexp = 1'b0;
          m_phase = (m_num == 0) ? P_DONE : P_RUN;
        end
        if (in_valid) begin
          if (cur == P_RUN && m_rcv < m_num) begin
            m_rcv++;
            if (m_occ < DEPTH) begin
              m_occ++;
              for (int i = 0; i < BEATS; i++) begin
                b.addr = m_addr;
                b.data = in_vector[i*64 +: 64];
                b.last = (i == BEATS - 1);
                exp_q.push_back(b);
                m_addr = m_addr + 32'd8;
              end
            end else begin
              m_ovf = 1'b1;
            end
          end else begin
            m_unexp = 1'b1;
          end
        end
      end
    end
  end

  task automatic doReset();
    mon_en          = 1'b0;
    rst             = 1'b1;
    cfg_start       = 1'b0;
    cfg_base_addr   = '0;
    cfg_num_vectors = '0;
    in_valid        = 1'b0;
    in_vector       = '0;
    idle(2);
    checkOutput("rst_wr_valid", wr_valid, 0);
    checkOutput("rst_wr_addr", wr_addr, 0);
    checkOutput("rst_wr_data", wr_data, 0);
    checkOutput("rst_wr_last", wr_last, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_err_overflow", err_overflow, 0);
    checkOutput("rst_err_unexpected", err_unexpected, 0);
    rst = 1'b0;
    resetModel();
    mon_en = 1'b1;
    idle(1);
  endtask

  task automatic startJob(input logic [31:0] base, input int num);
    cfg_start       = 1'b1;
    cfg_base_addr   = base;
    cfg_num_vectors = 16'(num);
    idle(1);
    cfg_start = 1'b0;
  endtask

  task automatic applyStimulus(input logic [255:0] vec);
    in_valid  = 1'b1;
    in_vector = vec;
    idle(1);
    in_valid = 1'b0;
  endtask

  task automatic waitDrain(input int max_cycles, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (exp_q.size() == 0 && (m_phase == P_IDLE || m_ovf)) begin
        ok = 1'b1;
        break;
      end
      idle(1);
    end
    if (!ok) failNow(name);
  endtask

  task automatic runJob(input job_t j, input int idx);
    string tag;
    tag        = $sformatf("job%0d", idx);
    nbeats     = 0;
    done_cnt   = 0;
    ready_mode = j.rmode;
    startJob(j.base, j.num);
    idle(1);
    for (int v = 0; v < j.nvec; v++) begin
      applyStimulus(randVec());
      idle(j.gap);
    end
    if (j.rmode == 3) begin
      idle(1);
      checkOutput({tag, "_ovf_while_stalled"}, err_overflow, j.exp_ovf);
      ready_mode = 0;
    end
    waitDrain(400, {tag, "_drain"});
    idle(3);
    checkOutput({tag, "_beats"}, nbeats, j.exp_beats);
    checkOutput({tag, "_err_overflow"}, err_overflow, j.exp_ovf);
    checkOutput({tag, "_err_unexpected"}, err_unexpected, j.exp_unexp);
    checkOutput({tag, "_done_pulses"}, done_cnt, j.exp_done);
    checkOutput({tag, "_busy"}, busy, !j.exp_done);
    if (j.exp_ovf) doReset();
  endtask

  initial begin
    job_t        jobs[6];
    logic [31:0] base;
    int          num;
    bit          seen;

    jobs[0] = '{32'h0000_1000, 2, 2, 10, 0, 1'b0, 1'b0, 1'b1, 8};
    jobs[1] = '{32'h0000_2000, 3, 3,  0, 1, 1'b0, 1'b0, 1'b1, 12};
    jobs[2] = '{32'h0000_3000, 6, 6,  0, 3, 1'b1, 1'b0, 1'b0, 16};
    jobs[3] = '{32'hFFFF_FFF0, 1, 1,  0, 0, 1'b0, 1'b0, 1'b1, 4};
    jobs[4] = '{32'h0000_0400, 1, 2,  2, 0, 1'b0, 1'b1, 1'b1, 4};
    jobs[5] = '{32'h0000_4000, 4, 4,  1, 2, 1'b0, 1'b0, 1'b1, 16};

    wr_ready   = 1'b0;
    ready_mode = 0;
    nbeats     = 0;
    done_cnt   = 0;
    resetModel();
    doReset();

    for (int j = 0; j < 6; j++) runJob(jobs[j], j);

    // Full FIFO with a new vector landing on the last-beat handshake;
    // also a cfg_start while busy, which must be ignored.
    ready_mode = 4;
    wr_ready   = 1'b0;
    nbeats     = 0;
    done_cnt   = 0;
    startJob(32'h0000_5000, 6);
    for (int v = 0; v < 4; v++) applyStimulus(randVec());
    startJob(32'hDEAD_0000, 9);
    idle(1);
    wr_ready = 1'b1;
    idle(3);
    applyStimulus(randVec());
    checkOutput("fullpop_err_overflow", err_overflow, 0);
    idle(4);
    applyStimulus(randVec());
    waitDrain(200, "fullpop_drain");
    idle(2);
    checkOutput("fullpop_beats", nbeats, 24);
    checkOutput("fullpop_done_pulses", done_cnt, 1);
    checkOutput("fullpop_err_overflow_end", err_overflow, 0);
    ready_mode = 0;

    // Unexpected vector while idle, then a zero-length job.
    idle(1);
    applyStimulus(randVec());
    checkOutput("unexp_in_idle", err_unexpected, 1);
    done_cnt = 0;
    startJob(32'h0000_8000, 0);
    checkOutput("zero_done", done, 1);
    checkOutput("zero_unexp_cleared", err_unexpected, 0);
    checkOutput("zero_no_valid", wr_valid, 0);
    checkOutput("zero_busy", busy, 0);
    idle(1);
    checkOutput("zero_done_one_cycle", done, 0);

    // Reset during the second beat, then a fresh job.
    nbeats   = 0;
    done_cnt = 0;
    startJob(32'h0000_6000, 2);
    applyStimulus(randVec());
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (nbeats >= 1) begin
        seen = 1'b1;
        break;
      end
      idle(1);
    end
    if (!seen) failNow("midrst_first_beat");
    mon_en = 1'b0;
    rst    = 1'b1;
    #1;
    checkOutput("midrst_wr_valid", wr_valid, 0);
    checkOutput("midrst_wr_addr", wr_addr, 0);
    checkOutput("midrst_wr_data", wr_data, 0);
    checkOutput("midrst_wr_last", wr_last, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_done", done, 0);
    idle(1);
    rst = 1'b0;
    resetModel();
    mon_en = 1'b1;
    idle(5);
    checkOutput("midrst_no_done", done_cnt, 0);
    nbeats = 0;
    startJob(32'h0000_7000, 1);
    applyStimulus(randVec());
    waitDrain(100, "midrst_fresh_drain");
    idle(2);
    checkOutput("midrst_fresh_beats", nbeats, 4);
    checkOutput("midrst_fresh_done", done_cnt, 1);

    // Randomized jobs with random backpressure and arrival gaps.
    for (int r = 0; r < 8; r++) begin
      base       = $urandom & 32'hFFFF_FFF8;
      num        = $urandom_range(1, 5);
      ready_mode = 2;
      nbeats     = 0;
      done_cnt   = 0;
      startJob(base, num);
      for (int v = 0; v < num; v++) begin
        idle($urandom_range(0, 4));
        for (int k = 0; k < 50 && m_occ >= DEPTH; k++) idle(1);
        applyStimulus(randVec());
      end
      waitDrain(600, "rand_drain");
      idle(2);
      checkOutput("rand_beats", nbeats, num * BEATS);
      checkOutput("rand_done", done_cnt, 1);
      checkOutput("rand_err_overflow", err_overflow, 0);
    end

    idle(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
